// File: rtl/division_if.sv
// Bundle between control unit and divider: start request, operands,
// state report and HI/LO results (divZero with DIVISION_DIV_ZERO_TRAP_EN).
interface division_if #(
    parameter int WIDTH = 32
);
    logic             enable;
    logic             isSigned;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [1:0]       stateOut;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;
`ifdef DIVISION_DIV_ZERO_TRAP_EN
    logic             divZero;

    modport master (
        output enable, isSigned, A, B,
        input  stateOut, HI, LO, divZero
    );
    modport slave (
        input  enable, isSigned, A, B,
        output stateOut, HI, LO, divZero
    );
`else
    modport master (
        output enable, isSigned, A, B,
        input  stateOut, HI, LO
    );
    modport slave (
        input  enable, isSigned, A, B,
        output stateOut, HI, LO
    );
`endif
endinterface

// File: rtl/division.sv
// Iterative restoring divider for DIV/DIVU: quotient -> LO, remainder -> HI.
// Ports: clock, reset (sync, active-low), bus (division_if.slave):
//   enable/isSigned/A/B in; stateOut/HI/LO out.
// Macro DIVISION_DIV_ZERO_TRAP_EN: adds divZero and skips DIVIDE when B==0.
module division #(
    parameter int WIDTH = 32
) (
    input logic       clock,
    input logic       reset,
    division_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [1:0] START  = 2'd0;
    localparam logic [1:0] DIVIDE = 2'd1;
    localparam logic [1:0] WRITE  = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             negq_q, negq_d;
    logic             negr_q, negr_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
`ifdef DIVISION_DIV_ZERO_TRAP_EN
    logic             dz_q, dz_d;
`endif

    // quo_q starts out holding the dividend; its MSB shifts into the
    // partial remainder while quotient bits fill in from the bottom.
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] rem_lo;

    assign shifted = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
    assign trial   = shifted - {1'b0, dvs_q};
    assign rem_lo  = rem_q[WIDTH-1:0];

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
`ifdef DIVISION_DIV_ZERO_TRAP_EN
        dz_d    = 1'b0;
`endif
        unique case (state_q)
            START: begin
                if (bus.enable) begin
                    if (bus.isSigned) begin
                        quo_d  = bus.A[WIDTH-1] ? -bus.A : bus.A;
                        dvs_d  = bus.B[WIDTH-1] ? -bus.B : bus.B;
                        negq_d = bus.A[WIDTH-1] ^ bus.B[WIDTH-1];
                        negr_d = bus.A[WIDTH-1];
                    end else begin
                        quo_d  = bus.A;
                        dvs_d  = bus.B;
                        negq_d = 1'b0;
                        negr_d = 1'b0;
                    end
                    rem_d   = '0;
                    cnt_d   = '0;
                    state_d = DIVIDE;
`ifdef DIVISION_DIV_ZERO_TRAP_EN
                    if (bus.B == '0) begin
                        state_d = DONE;
                        dz_d    = 1'b1;
                    end
`endif
                end
            end
            DIVIDE: begin
                // Trial MSB clear means the divisor fits.
                if (!trial[WIDTH]) begin
                    rem_d = trial;
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = shifted;
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                lo_d    = negq_q ? -quo_q : quo_q;
                hi_d    = negr_q ? -rem_lo : rem_lo;
                state_d = DONE;
            end
            DONE: begin
                rem_d   = '0;
                quo_d   = '0;
                dvs_d   = '0;
                cnt_d   = '0;
                negq_d  = 1'b0;
                negr_d  = 1'b0;
                state_d = START;
            end
            default: begin
                state_d = START;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= START;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
`ifdef DIVISION_DIV_ZERO_TRAP_EN
            dz_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
`ifdef DIVISION_DIV_ZERO_TRAP_EN
            dz_q    <= dz_d;
`endif
        end
    end

    assign bus.stateOut = state_q;
    assign bus.HI       = hi_q;
    assign bus.LO       = lo_q;
`ifdef DIVISION_DIV_ZERO_TRAP_EN
    assign bus.divZero  = dz_q;
`endif
endmodule

// File: tb/tb_division.sv
// Scoreboard bench for division: directed vectors queue expected HI/LO,
// a negedge monitor checks them whenever stateOut reports DONE.
module tb_division;
    logic clock;
    logic reset;

    division_if bus ();

    division dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          ndiv;
        logic        dz;
    } exp_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    int          ndiv     = 0;
    logic [31:0] last_hi  = '0;
    logic [31:0] last_lo  = '0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: counts DIVIDE cycles and checks results at DONE.
    always @(negedge clock) begin
        exp_t e;
        if (bus.stateOut == 2'd1) begin
            ndiv++;
        end else if (bus.stateOut == 2'd3) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected_done actual=%0d required=0", 1);
            end else begin
                e = sb.pop_front();
                chk("done_LO", bus.LO, e.lo);
                chk("done_HI", bus.HI, e.hi);
                chk("divide_cycles", 32'(ndiv), 32'(e.ndiv));
`ifdef DIVISION_DIV_ZERO_TRAP_EN
                chk("divZero", 32'(bus.divZero), 32'(e.dz));
`endif
            end
            ndiv = 0;
        end else if (bus.stateOut == 2'd0) begin
            ndiv = 0;
        end
    end

    task automatic run_op(input logic s, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi,
                          input logic [31:0] elo, input bit tog);
        exp_t e;
        bit   back;
        e.hi   = ehi;
        e.lo   = elo;
        e.ndiv = 32;
        e.dz   = 1'b0;
`ifdef DIVISION_DIV_ZERO_TRAP_EN
        if (b == 32'd0) begin
            e.hi   = last_hi;
            e.lo   = last_lo;
            e.ndiv = 0;
            e.dz   = 1'b1;
        end
`endif
        sb.push_back(e);
        @(negedge clock);
        bus.isSigned = s;
        bus.A        = a;
        bus.B        = b;
        bus.enable   = 1'b1;
        @(negedge clock);
        bus.enable = 1'b0;
        back = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (bus.stateOut == 2'd0) begin
                back = 1'b1;
                break;
            end
            if (tog) begin
                bus.enable = (bus.stateOut == 2'd1) ? ~bus.enable : 1'b0;
                bus.A      = bus.A ^ 32'h5a5a_0000;
            end
            @(negedge clock);
        end
        bus.enable = 1'b0;
        if (!back) begin
            checks++;
            failures++;
            $display("FAIL op_timeout actual=%0d required=0", bus.stateOut);
        end
        chk("hold_LO", bus.LO, e.lo);
        chk("hold_HI", bus.HI, e.hi);
        last_hi = e.hi;
        last_lo = e.lo;
    endtask

    initial begin
        reset        = 1'b0;
        bus.enable   = 1'b0;
        bus.isSigned = 1'b0;
        bus.A        = '0;
        bus.B        = '0;
        repeat (3) @(negedge clock);
        chk("reset_state", 32'(bus.stateOut), 32'd0);
        chk("reset_HI", bus.HI, 32'd0);
        chk("reset_LO", bus.LO, 32'd0);
        reset = 1'b1;

        run_op(1, 32'd100, 32'd7, 32'd2, 32'd14, 0);
        run_op(1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFF2, 0);
        run_op(1, 32'd100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFF2, 0);
        run_op(0, 32'hFFFF_FFFF, 32'd2, 32'd1, 32'h7FFF_FFFF, 0);
        run_op(1, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'd0, 0);
        run_op(1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 0);
        run_op(1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd3, 0);
        run_op(0, 32'h8000_0000, 32'h0000_0010, 32'd0, 32'h0800_0000, 0);
        run_op(1, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 0);

        // Abort mid-division: reset during the 10th DIVIDE cycle.
        @(negedge clock);
        bus.isSigned = 1'b1;
        bus.A        = 32'd100;
        bus.B        = 32'd7;
        bus.enable   = 1'b1;
        @(posedge clock);
        #1 bus.enable = 1'b0;
        repeat (9) @(posedge clock);
        #1 reset = 1'b0;
        @(posedge clock);
        #1;
        chk("abort_state", 32'(bus.stateOut), 32'd0);
        chk("abort_HI", bus.HI, 32'd0);
        chk("abort_LO", bus.LO, 32'd0);
        @(negedge clock);
        reset   = 1'b1;
        last_hi = '0;
        last_lo = '0;

        run_op(0, 32'd81, 32'd9, 32'd0, 32'd9, 1);

        repeat (3) @(negedge clock);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=%0t required=done", $time);
        $fatal(1, "timeout");
    end
endmodule
